decode_trace_emitter: RTL and testbench

- Producer side of the decode-stage register-specifier observation path. Sits inside the pipelined MIPS core next to the decode stage.
- Samples rs/rt/rd of each instruction accepted by decode, timestamps it and buffers it in a small FIFO.
- Presents records to an external reader (bench, debug logic) over a valid/ready handshake, so the reader no longer probes internal nets.

---
 rtl/decode_trace_emitter.sv | 144 ++++++++++++++
 tb/tb_decode_trace_emitter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/decode_trace_emitter.sv
// decode_trace_emitter
// Producer side of the decode-stage register-specifier observation path.
// Each instruction that decode accepts has its rs/rt/rd sampled and stamped
// with a free-running cycle count. The record is buffered in a small FIFO and
// handed to an external reader over a valid/ready handshake.
//
// Ports:
//   clk_i          rising-edge clock
//   reset_i        synchronous reset, active-low
//   enable_i       capture enable
//   stall_d_i      decode stalled (no capture)
//   flush_d_i      decode flushed / bubble (no capture)
//   rs_d_i/rt_d_i/rd_d_i  decode register specifiers
//   trace_valid_o  head record available
//   trace_ready_i  reader accepts head record
//   trace_data_o   {stamp, rs, rt, rd}, rd in bits [4:0]
//   count_o        current FIFO occupancy
//   dropped_o      saturating count of records lost to overflow
//   overflow_o     sticky flag, set on the first drop since reset
//
// Build option: define TRACE_NOP_FILTER_EN to suppress all-zero specifier
// records (sll $0,$0,0). Default build records every capture.
module decode_trace_emitter #(
  parameter int DEPTH   = 8,
  parameter int STAMP_W = 16,
  parameter int DROP_W  = 8
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       enable_i,
  input  logic                       stall_d_i,
  input  logic                       flush_d_i,
  input  logic [4:0]                 rs_d_i,
  input  logic [4:0]                 rt_d_i,
  input  logic [4:0]                 rd_d_i,
  output logic                       trace_valid_o,
  input  logic                       trace_ready_i,
  output logic [STAMP_W+14:0]        trace_data_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic [DROP_W-1:0]          dropped_o,
  output logic                       overflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = STAMP_W + 15;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DW-1:0]     mem_r [DEPTH];
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [CW-1:0]     count_r;
  logic [STAMP_W-1:0] stamp_r;
  logic [DROP_W-1:0] dropped_r;
  logic              overflow_r;

  logic cap_s;
  logic nop_s;
  logic rec_s;
  logic pop_s;
  logic full_s;
  logic push_s;
  logic drop_s;

  // Capture / pop / drop decisions for this cycle.
  always_comb begin
    cap_s  = 1'b0;
    nop_s  = 1'b0;
    rec_s  = 1'b0;
    pop_s  = 1'b0;
    full_s = 1'b0;
    push_s = 1'b0;
    drop_s = 1'b0;

    cap_s = enable_i & ~stall_d_i & ~flush_d_i;
`ifdef TRACE_NOP_FILTER_EN
    nop_s = (rs_d_i == 5'd0) && (rt_d_i == 5'd0) && (rd_d_i == 5'd0);
`else
    nop_s = 1'b0;
`endif
    rec_s  = cap_s & ~nop_s;
    pop_s  = (count_r != {CW{1'b0}}) & trace_ready_i;
    full_s = (count_r == FULL_CNT);
    // A pop in the same edge frees the slot, so a full FIFO still accepts.
    push_s = rec_s & (~full_s | pop_s);
    drop_s = rec_s & full_s & ~pop_s;
  end

  // Record storage; contents are don't-care outside the occupied window.
  always_ff @(posedge clk_i) begin
    if (reset_i && push_s) begin
      mem_r[wr_ptr_r] <= {stamp_r, rs_d_i, rt_d_i, rd_d_i};
    end
  end

  // Pointers, occupancy, stamp and overflow bookkeeping.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      count_r    <= {CW{1'b0}};
      stamp_r    <= {STAMP_W{1'b0}};
      dropped_r  <= {DROP_W{1'b0}};
      overflow_r <= 1'b0;
    end else begin
      stamp_r <= stamp_r + STAMP_W'(1);
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
      if (drop_s) begin
        overflow_r <= 1'b1;
        if (dropped_r != {DROP_W{1'b1}}) begin
          dropped_r <= dropped_r + DROP_W'(1);
        end
      end
    end
  end

  // Output view of the registered state; data reads zero while empty.
  always_comb begin
    trace_valid_o = 1'b0;
    trace_data_o  = {DW{1'b0}};
    if (count_r != {CW{1'b0}}) begin
      trace_valid_o = 1'b1;
      trace_data_o  = mem_r[rd_ptr_r];
    end else begin
      trace_valid_o = 1'b0;
      trace_data_o  = {DW{1'b0}};
    end
  end

  assign count_o    = count_r;
  assign dropped_o  = dropped_r;
  assign overflow_o = overflow_r;

endmodule

// File: tb/tb_decode_trace_emitter.sv
module tb_decode_trace_emitter;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        enable_i;
  logic        stall_d_i;
  logic        flush_d_i;
  logic [4:0]  rs_d_i;
  logic [4:0]  rt_d_i;
  logic [4:0]  rd_d_i;
  logic        trace_valid_o;
  logic        trace_ready_i;
  logic [30:0] trace_data_o;
  logic [3:0]  count_o;
  logic [7:0]  dropped_o;
  logic        overflow_o;

  int checks = 0;
  int errors = 0;
  logic [15:0] stamp_m;
  logic [30:0] exp_q[$];

  decode_trace_emitter dut (
    .clk_i(clk), .reset_i(reset_i), .enable_i(enable_i),
    .stall_d_i(stall_d_i), .flush_d_i(flush_d_i),
    .rs_d_i(rs_d_i), .rt_d_i(rt_d_i), .rd_d_i(rd_d_i),
    .trace_valid_o(trace_valid_o), .trace_ready_i(trace_ready_i),
    .trace_data_o(trace_data_o), .count_o(count_o),
    .dropped_o(dropped_o), .overflow_o(overflow_o)
  );

  always #5 clk = ~clk;

  // One clock edge; tracks the expected stamp and settles #1 past the edge.
  task automatic tick();
    @(posedge clk);
    if (reset_i) stamp_m = stamp_m + 16'd1;
    else         stamp_m = 16'd0;
    #1;
  endtask

  task automatic set_spec(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    rs_d_i = rs; rt_d_i = rt; rd_d_i = rd;
  endtask

  task automatic test_reset();
    reset_i = 1'b0; enable_i = 1'b0; stall_d_i = 1'b0; flush_d_i = 1'b0;
    trace_ready_i = 1'b0; set_spec(5'd0, 5'd0, 5'd0);
    tick(); tick();
    checks++; if (trace_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", trace_valid_o); end
    checks++; if (trace_data_o !== 31'd0) begin errors++; $display("FAIL reset_data got %h want 0", trace_data_o); end
    checks++; if (count_o !== 4'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count_o); end
    checks++; if (dropped_o !== 8'd0 || overflow_o !== 1'b0) begin errors++; $display("FAIL reset_drop got %0d/%0b want 0/0", dropped_o, overflow_o); end
    reset_i = 1'b1;
  endtask

  task automatic test_basic();
    logic [15:0] s0;
    enable_i = 1'b1; set_spec(5'd3, 5'd4, 5'd5); s0 = stamp_m;
    tick();
    enable_i = 1'b0;
    checks++; if (trace_valid_o !== 1'b1) begin errors++; $display("FAIL basic_valid got %0b want 1", trace_valid_o); end
    checks++; if (trace_data_o !== {s0, 5'd3, 5'd4, 5'd5}) begin errors++; $display("FAIL basic_data got %h want %h", trace_data_o, {s0, 5'd3, 5'd4, 5'd5}); end
    checks++; if (count_o !== 4'd1) begin errors++; $display("FAIL basic_count got %0d want 1", count_o); end
    // Held stable while not ready.
    tick();
    checks++; if (trace_data_o !== {s0, 5'd3, 5'd4, 5'd5}) begin errors++; $display("FAIL basic_hold got %h want %h", trace_data_o, {s0, 5'd3, 5'd4, 5'd5}); end
    trace_ready_i = 1'b1;
    tick();
    trace_ready_i = 1'b0;
    checks++; if (count_o !== 4'd0 || trace_valid_o !== 1'b0) begin errors++; $display("FAIL basic_drain got %0d/%0b want 0/0", count_o, trace_valid_o); end
  endtask

  task automatic test_no_bypass();
    logic [15:0] s0;
    enable_i = 1'b1; trace_ready_i = 1'b1; set_spec(5'd9, 5'd10, 5'd11); s0 = stamp_m;
    tick();
    enable_i = 1'b0;
    checks++; if (count_o !== 4'd1 || trace_data_o !== {s0, 5'd9, 5'd10, 5'd11}) begin errors++; $display("FAIL nobypass got %0d/%h want 1/%h", count_o, trace_data_o, {s0, 5'd9, 5'd10, 5'd11}); end
    tick();
    trace_ready_i = 1'b0;
    checks++; if (count_o !== 4'd0) begin errors++; $display("FAIL nobypass_pop got %0d want 0", count_o); end
  endtask

  task automatic test_stall_flush();
    logic [15:0] s1;
    trace_ready_i = 1'b0; enable_i = 1'b1;
    set_spec(5'd1, 5'd2, 5'd3); s1 = stamp_m; tick();
    stall_d_i = 1'b1; set_spec(5'd7, 5'd7, 5'd7); tick();
    stall_d_i = 1'b0; flush_d_i = 1'b1; set_spec(5'd8, 5'd8, 5'd8); tick();
    flush_d_i = 1'b0; set_spec(5'd4, 5'd5, 5'd6); tick();
    enable_i = 1'b0;
    checks++; if (count_o !== 4'd2) begin errors++; $display("FAIL stall_count got %0d want 2", count_o); end
    checks++; if (trace_data_o !== {s1, 5'd1, 5'd2, 5'd3}) begin errors++; $display("FAIL stall_rec0 got %h want %h", trace_data_o, {s1, 5'd1, 5'd2, 5'd3}); end
    trace_ready_i = 1'b1; tick();
    checks++; if (trace_data_o !== {s1 + 16'd3, 5'd4, 5'd5, 5'd6}) begin errors++; $display("FAIL stall_rec1 got %h want %h", trace_data_o, {s1 + 16'd3, 5'd4, 5'd5, 5'd6}); end
    tick(); trace_ready_i = 1'b0;
    checks++; if (count_o !== 4'd0) begin errors++; $display("FAIL stall_drain got %0d want 0", count_o); end
  endtask

  task automatic test_overflow();
    logic [30:0] exp;
    trace_ready_i = 1'b0; enable_i = 1'b1; exp_q.delete();
    for (int i = 0; i < 10; i++) begin
      set_spec(5'(i), 5'(i + 1), 5'(i + 2));
      if (i < 8) exp_q.push_back({stamp_m, 5'(i), 5'(i + 1), 5'(i + 2)});
      tick();
    end
    enable_i = 1'b0;
    checks++; if (count_o !== 4'd8) begin errors++; $display("FAIL ovf_count got %0d want 8", count_o); end
    checks++; if (dropped_o !== 8'd2) begin errors++; $display("FAIL ovf_dropped got %0d want 2", dropped_o); end
    checks++; if (overflow_o !== 1'b1) begin errors++; $display("FAIL ovf_flag got %0b want 1", overflow_o); end
    trace_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp = exp_q.pop_front();
      checks++; if (trace_data_o !== exp) begin errors++; $display("FAIL ovf_drain%0d got %h want %h", i, trace_data_o, exp); end
      tick();
    end
    trace_ready_i = 1'b0;
    checks++; if (count_o !== 4'd0 || trace_valid_o !== 1'b0) begin errors++; $display("FAIL ovf_empty got %0d/%0b want 0/0", count_o, trace_valid_o); end
  endtask

  task automatic test_full_push_pop();
    logic [30:0] exp;
    trace_ready_i = 1'b0; enable_i = 1'b1; exp_q.delete();
    for (int i = 0; i < 8; i++) begin
      set_spec(5'(10 + i), 5'(i), 5'(20 + i));
      exp_q.push_back({stamp_m, 5'(10 + i), 5'(i), 5'(20 + i)});
      tick();
    end
    trace_ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_spec(5'(i), 5'(30 - i), 5'd17);
      exp = exp_q.pop_front();
      checks++; if (trace_data_o !== exp) begin errors++; $display("FAIL fpp_head%0d got %h want %h", i, trace_data_o, exp); end
      exp_q.push_back({stamp_m, 5'(i), 5'(30 - i), 5'd17});
      tick();
      checks++; if (count_o !== 4'd8) begin errors++; $display("FAIL fpp_count%0d got %0d want 8", i, count_o); end
    end
    enable_i = 1'b0;
    checks++; if (dropped_o !== 8'd2) begin errors++; $display("FAIL fpp_dropped got %0d want 2", dropped_o); end
    for (int i = 0; i < 8; i++) begin
      exp = exp_q.pop_front();
      checks++; if (trace_data_o !== exp) begin errors++; $display("FAIL fpp_drain%0d got %h want %h", i, trace_data_o, exp); end
      tick();
    end
    trace_ready_i = 1'b0;
    checks++; if (count_o !== 4'd0) begin errors++; $display("FAIL fpp_empty got %0d want 0", count_o); end
  endtask

  task automatic test_reset_mid();
    trace_ready_i = 1'b0; enable_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_spec(5'(i + 1), 5'd1, 5'd2); tick();
    end
    enable_i = 1'b0; reset_i = 1'b0; tick(); reset_i = 1'b1;
    checks++; if (trace_valid_o !== 1'b0 || count_o !== 4'd0) begin errors++; $display("FAIL rmid_empty got %0b/%0d want 0/0", trace_valid_o, count_o); end
    checks++; if (dropped_o !== 8'd0 || overflow_o !== 1'b0) begin errors++; $display("FAIL rmid_drop got %0d/%0b want 0/0", dropped_o, overflow_o); end
    enable_i = 1'b1; set_spec(5'd6, 5'd7, 5'd8); tick(); enable_i = 1'b0;
    checks++; if (trace_data_o !== {16'd0, 5'd6, 5'd7, 5'd8}) begin errors++; $display("FAIL rmid_stamp got %h want %h", trace_data_o, {16'd0, 5'd6, 5'd7, 5'd8}); end
    trace_ready_i = 1'b1; tick(); trace_ready_i = 1'b0;
  endtask

  task automatic test_nop_filter();
    trace_ready_i = 1'b0; enable_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) set_spec(5'd0, 5'd0, 5'd0);
      else            set_spec(5'd1, 5'd2, 5'd3);
      tick();
    end
    enable_i = 1'b0;
`ifdef TRACE_NOP_FILTER_EN
    checks++; if (count_o !== 4'd3) begin errors++; $display("FAIL nop_count got %0d want 3", count_o); end
    trace_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (trace_data_o[14:0] !== {5'd1, 5'd2, 5'd3}) begin errors++; $display("FAIL nop_rec%0d got %h want %h", i, trace_data_o[14:0], {5'd1, 5'd2, 5'd3}); end
      tick();
    end
`else
    checks++; if (count_o !== 4'd6) begin errors++; $display("FAIL nop_count got %0d want 6", count_o); end
    trace_ready_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) begin
        checks++; if (trace_data_o[14:0] !== 15'd0) begin errors++; $display("FAIL nop_rec%0d got %h want 0", i, trace_data_o[14:0]); end
      end else begin
        checks++; if (trace_data_o[14:0] !== {5'd1, 5'd2, 5'd3}) begin errors++; $display("FAIL nop_rec%0d got %h want %h", i, trace_data_o[14:0], {5'd1, 5'd2, 5'd3}); end
      end
      tick();
    end
`endif
    trace_ready_i = 1'b0;
    checks++; if (count_o !== 4'd0 || dropped_o !== 8'd0) begin errors++; $display("FAIL nop_end got %0d/%0d want 0/0", count_o, dropped_o); end
  endtask

  initial begin
    stamp_m = 16'd0;
    test_reset();
    test_basic();
    test_no_bypass();
    test_stall_flush();
    test_overflow();
    test_full_push_pop();
    test_reset_mid();
    test_nop_filter();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
